// File: rtl/gearbox_sched.sv
// Flow-control scheduler for the 16-to-20-bit nibble gearbox: write/read strobes, occupancy, zero-pad flush.
// Optional frame counter is built when GEARBOX_SCHED_STATS_EN is defined.
module gearbox_sched #(
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        up_valid,
    output logic        up_ready,
    input  logic        dn_ready,
    output logic        dn_valid,
    input  logic        flush,
    output logic        flush_done,
    output logic        gb_shift_in,
    output logic        gb_shift_out,
    output logic        gb_pad,
    output logic [5:0]  level,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;

    localparam logic [5:0] SPACE_MAX = 6'(DEPTH - 4);

    state_t            state_q, state_d;
    logic [5:0]        level_q, level_d;
    logic [2:0]        pad_cnt_q, pad_cnt_d;
    logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;

    logic       space_ok;
    logic       rd_ok;
    logic       accepting;
    logic       up_wr;
    logic       pad_wr;
    logic [2:0] flush_pad;

    always_comb begin
        space_ok     = (level_q <= SPACE_MAX);
        rd_ok        = (level_q >= 6'd5);
        accepting    = (state_q == IDLE) || (state_q == RUN);
        up_ready     = res_n & space_ok & accepting;
        up_wr        = up_valid & up_ready;
        pad_wr       = res_n & (state_q == FLUSH) & (pad_cnt_q != 3'd0) & space_ok;
        gb_shift_in  = up_wr | pad_wr;
        gb_pad       = pad_wr;
        gb_shift_out = res_n & dn_ready & rd_ok;
        level_d      = level_q + (gb_shift_in ? 6'd4 : 6'd0) - (gb_shift_out ? 6'd5 : 6'd0);
        // Each pad word removes one nibble mod 5, so this many pads leaves a whole number of frames.
        flush_pad    = 3'(level_d % 6'd5);
    end

    always_comb begin
        state_d   = state_q;
        pad_cnt_d = pad_cnt_q;
        case (state_q)
            IDLE: begin
                if (flush && up_wr) begin
                    pad_cnt_d = flush_pad;
                    state_d   = (flush_pad == 3'd0) ? DRAIN : FLUSH;
                end else if (flush) begin
                    state_d = DONE;
                end else if (up_wr) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    pad_cnt_d = flush_pad;
                    state_d   = (flush_pad == 3'd0) ? DRAIN : FLUSH;
                end
            end
            FLUSH: begin
                if (pad_wr) begin
                    pad_cnt_d = pad_cnt_q - 3'd1;
                    if (pad_cnt_q == 3'd1) begin
                        state_d = DRAIN;
                    end
                end else if (pad_cnt_q == 3'd0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (level_q == 6'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    genvar gi;
    assign rd_pipe_d[0] = gb_shift_out;
    generate
        for (gi = 1; gi < RD_LAT; gi++) begin : g_rd_pipe
            assign rd_pipe_d[gi] = rd_pipe_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= IDLE;
            level_q   <= 6'd0;
            pad_cnt_q <= 3'd0;
            rd_pipe_q <= '0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            pad_cnt_q <= pad_cnt_d;
            rd_pipe_q <= rd_pipe_d;
        end
    end

    assign dn_valid   = rd_pipe_q[RD_LAT-1];
    assign level      = level_q;
    assign busy       = (state_q != IDLE);
    assign flush_done = (state_q == DONE);

`ifdef GEARBOX_SCHED_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q + (gb_shift_out ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_gearbox_sched.sv
// Directed bench for gearbox_sched: fill, drain, streaming, flush paths and asynchronous reset.
`timescale 1ns/1ps
module tb_gearbox_sched;

    logic        clk = 1'b0;
    logic        res_n = 1'b1;
    logic        up_valid = 1'b0;
    logic        up_ready;
    logic        dn_ready = 1'b0;
    logic        dn_valid;
    logic        flush = 1'b0;
    logic        flush_done;
    logic        gb_shift_in;
    logic        gb_shift_out;
    logic        gb_pad;
    logic [5:0]  level;
    logic        busy;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;
    int nrd;
    int exp_lvl;
    int exp_fc;
    logic e_in, e_out;

    always #5 clk = ~clk;

    gearbox_sched #(.DEPTH(32), .RD_LAT(2)) dut (
        .clk(clk), .res_n(res_n),
        .up_valid(up_valid), .up_ready(up_ready),
        .dn_ready(dn_ready), .dn_valid(dn_valid),
        .flush(flush), .flush_done(flush_done),
        .gb_shift_in(gb_shift_in), .gb_shift_out(gb_shift_out), .gb_pad(gb_pad),
        .level(level), .busy(busy), .frame_cnt(frame_cnt)
    );

    task automatic report(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Drive inputs just after the falling edge; checks follow 1ns later, far from the rising edge.
    task automatic drive(input logic uv, input logic dr, input logic fl);
        @(negedge clk);
        up_valid = uv;
        dn_ready = dr;
        flush    = fl;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        up_valid = 1'b0;
        dn_ready = 1'b0;
        flush    = 1'b0;
        res_n    = 1'b0;
        repeat (2) @(negedge clk);
        res_n = 1'b1;
    endtask

    initial begin
        // Reset with active inputs: strobes must stay low.
        #1;
        up_valid = 1'b1;
        dn_ready = 1'b1;
        flush    = 1'b1;
        res_n    = 1'b0;
        #2;
        checks++; if (level !== 6'd0) report("rst_level", level, 0);
        checks++; if (up_ready !== 1'b0) report("rst_up_ready", up_ready, 0);
        checks++; if (gb_shift_in !== 1'b0) report("rst_shift_in", gb_shift_in, 0);
        checks++; if (gb_shift_out !== 1'b0) report("rst_shift_out", gb_shift_out, 0);
        checks++; if (busy !== 1'b0) report("rst_busy", busy, 0);
        checks++; if (flush_done !== 1'b0) report("rst_flush_done", flush_done, 0);
        checks++; if (dn_valid !== 1'b0) report("rst_dn_valid", dn_valid, 0);
        checks++; if (frame_cnt !== 16'd0) report("rst_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        up_valid = 1'b0;
        dn_ready = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        res_n = 1'b1;

        // Fill: eight writes, then full.
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0);
            checks++; if (level !== 6'(4 * i)) report("fill_level", level, 4 * i);
            checks++; if (gb_shift_in !== 1'b1) report("fill_shift_in", gb_shift_in, 1);
            checks++; if (gb_shift_out !== 1'b0) report("fill_shift_out", gb_shift_out, 0);
        end
        drive(1, 0, 0);
        checks++; if (level !== 6'd32) report("full_level", level, 32);
        checks++; if (up_ready !== 1'b0) report("full_up_ready", up_ready, 0);
        checks++; if (gb_shift_in !== 1'b0) report("full_shift_in", gb_shift_in, 0);
        checks++; if (busy !== 1'b1) report("full_busy", busy, 1);
        $display("fill: level=%0d up_ready=%0b", level, up_ready);

        // Drain: six reads, dn_valid two cycles behind each read.
        for (int j = 0; j < 6; j++) begin
            drive(0, 1, 0);
            checks++; if (level !== 6'(32 - 5 * j)) report("drain_level", level, 32 - 5 * j);
            checks++; if (gb_shift_out !== 1'b1) report("drain_shift_out", gb_shift_out, 1);
            checks++; if (dn_valid !== ((j >= 2) ? 1'b1 : 1'b0)) report("drain_dn_valid", dn_valid, (j >= 2) ? 1 : 0);
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0);
            checks++; if (level !== 6'd2) report("drain_stop_level", level, 2);
            checks++; if (gb_shift_out !== 1'b0) report("drain_stop_shift_out", gb_shift_out, 0);
            checks++; if (dn_valid !== ((k < 2) ? 1'b1 : 1'b0)) report("drain_tail_dn_valid", dn_valid, (k < 2) ? 1 : 0);
        end
        $display("drain: level=%0d", level);

        // Streaming with both strobes active.
        exp_lvl = 2;
        for (int c = 0; c < 200; c++) begin
            drive(1, 1, 0);
            e_in  = (exp_lvl <= 28);
            e_out = (exp_lvl >= 5);
            checks++; if (level !== 6'(exp_lvl)) report("stream_level", level, exp_lvl);
            checks++; if (gb_shift_in !== e_in) report("stream_shift_in", gb_shift_in, e_in);
            checks++; if (gb_shift_out !== e_out) report("stream_shift_out", gb_shift_out, e_out);
            exp_lvl = exp_lvl + (e_in ? 4 : 0) - (e_out ? 5 : 0);
        end
        $display("stream: level=%0d after 200 cycles", level);

        // Flush at level 12 with reads running: two pads, four frames.
        do_reset();
        nrd = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0);
            checks++; if (level !== 6'(4 * i)) report("fl12_wr_level", level, 4 * i);
        end
        drive(0, 1, 1);
        nrd += int'(gb_shift_out);
        checks++; if (level !== 6'd12) report("fl12_req_level", level, 12);
        checks++; if (gb_shift_out !== 1'b1) report("fl12_req_shift_out", gb_shift_out, 1);
        drive(1, 1, 0);
        nrd += int'(gb_shift_out);
        checks++; if (level !== 6'd7) report("fl12_pad1_level", level, 7);
        checks++; if (gb_pad !== 1'b1) report("fl12_pad1_gb_pad", gb_pad, 1);
        checks++; if (gb_shift_in !== 1'b1) report("fl12_pad1_shift_in", gb_shift_in, 1);
        checks++; if (up_ready !== 1'b0) report("fl12_pad1_up_ready", up_ready, 0);
        drive(1, 1, 0);
        nrd += int'(gb_shift_out);
        checks++; if (level !== 6'd6) report("fl12_pad2_level", level, 6);
        checks++; if (gb_pad !== 1'b1) report("fl12_pad2_gb_pad", gb_pad, 1);
        drive(1, 1, 0);
        nrd += int'(gb_shift_out);
        checks++; if (level !== 6'd5) report("fl12_drain_level", level, 5);
        checks++; if (gb_pad !== 1'b0) report("fl12_drain_gb_pad", gb_pad, 0);
        checks++; if (gb_shift_in !== 1'b0) report("fl12_drain_shift_in", gb_shift_in, 0);
        drive(1, 1, 0);
        nrd += int'(gb_shift_out);
        checks++; if (level !== 6'd0) report("fl12_empty_level", level, 0);
        checks++; if (flush_done !== 1'b0) report("fl12_empty_flush_done", flush_done, 0);
        checks++; if (gb_shift_in !== 1'b0) report("fl12_empty_shift_in", gb_shift_in, 0);
        drive(0, 1, 0);
        nrd += int'(gb_shift_out);
        checks++; if (flush_done !== 1'b1) report("fl12_done_pulse", flush_done, 1);
        checks++; if (busy !== 1'b1) report("fl12_done_busy", busy, 1);
        drive(0, 1, 0);
        checks++; if (flush_done !== 1'b0) report("fl12_after_flush_done", flush_done, 0);
        checks++; if (busy !== 1'b0) report("fl12_after_busy", busy, 0);
        checks++; if (nrd !== 4) report("fl12_frames", nrd, 4);
`ifdef GEARBOX_SCHED_STATS_EN
        exp_fc = 4;
`else
        exp_fc = 0;
`endif
        checks++; if (frame_cnt !== 16'(exp_fc)) report("fl12_frame_cnt", frame_cnt, exp_fc);
        $display("flush12: frames=%0d frame_cnt=%0d", nrd, frame_cnt);

        // Flush while idle and empty.
        drive(0, 0, 1);
        checks++; if (gb_shift_in !== 1'b0) report("idle_fl_shift_in", gb_shift_in, 0);
        checks++; if (flush_done !== 1'b0) report("idle_fl_flush_done", flush_done, 0);
        drive(0, 0, 0);
        checks++; if (flush_done !== 1'b1) report("idle_fl_done", flush_done, 1);
        checks++; if (gb_shift_out !== 1'b0) report("idle_fl_shift_out", gb_shift_out, 0);
        drive(0, 0, 0);
        checks++; if (flush_done !== 1'b0) report("idle_fl_after", flush_done, 0);
        checks++; if (busy !== 1'b0) report("idle_fl_busy", busy, 0);
        $display("idle flush: done");

        // Flush at level 10: no pads, two frames.
        for (int i = 0; i < 4; i++) drive(1, 0, 0);
        drive(0, 1, 0);
        checks++; if (level !== 6'd16) report("fl10_lvl16", level, 16);
        drive(1, 1, 0);
        checks++; if (level !== 6'd11) report("fl10_lvl11", level, 11);
        drive(0, 0, 1);
        checks++; if (level !== 6'd10) report("fl10_req_level", level, 10);
        nrd = 0;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0);
            nrd += int'(gb_shift_out);
            checks++; if (gb_pad !== 1'b0) report("fl10_gb_pad", gb_pad, 0);
            checks++; if (gb_shift_in !== 1'b0) report("fl10_shift_in", gb_shift_in, 0);
            checks++; if (level !== 6'(10 - 5 * i)) report("fl10_level", level, 10 - 5 * i);
        end
        drive(0, 1, 0);
        checks++; if (gb_shift_out !== 1'b0) report("fl10_empty_shift_out", gb_shift_out, 0);
        drive(0, 0, 0);
        checks++; if (flush_done !== 1'b1) report("fl10_done", flush_done, 1);
        checks++; if (nrd !== 2) report("fl10_frames", nrd, 2);
        $display("flush10: frames=%0d", nrd);

        // Stall in FLUSH at level 31 with one pad pending, then reset asynchronously.
        drive(0, 0, 0);
        for (int i = 0; i < 8; i++) drive(1, 0, 0);
        drive(0, 1, 0);
        drive(1, 0, 0);
        checks++; if (level !== 6'd27) report("rf_lvl27", level, 27);
        drive(0, 0, 1);
        checks++; if (level !== 6'd31) report("rf_lvl31", level, 31);
        drive(0, 0, 0);
        checks++; if (gb_pad !== 1'b0) report("rf_stall_gb_pad", gb_pad, 0);
        checks++; if (busy !== 1'b1) report("rf_stall_busy", busy, 1);
        #2;
        up_valid = 1'b1;
        dn_ready = 1'b1;
        res_n    = 1'b0;
        #1;
        checks++; if (level !== 6'd0) report("rf_async_level", level, 0);
        checks++; if (busy !== 1'b0) report("rf_async_busy", busy, 0);
        checks++; if (up_ready !== 1'b0) report("rf_async_up_ready", up_ready, 0);
        checks++; if (gb_shift_in !== 1'b0) report("rf_async_shift_in", gb_shift_in, 0);
        checks++; if (gb_shift_out !== 1'b0) report("rf_async_shift_out", gb_shift_out, 0);
        checks++; if (gb_pad !== 1'b0) report("rf_async_gb_pad", gb_pad, 0);
        checks++; if (flush_done !== 1'b0) report("rf_async_flush_done", flush_done, 0);
        checks++; if (frame_cnt !== 16'd0) report("rf_async_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        #1;
        checks++; if (dn_valid !== 1'b0) report("rf_held_dn_valid", dn_valid, 0);
        checks++; if (level !== 6'd0) report("rf_held_level", level, 0);
        up_valid = 1'b0;
        dn_ready = 1'b0;
        res_n    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0);
            checks++; if (flush_done !== 1'b0) report("rf_post_flush_done", flush_done, 0);
            checks++; if (busy !== 1'b0) report("rf_post_busy", busy, 0);
        end
        $display("reset mid-flush: level=%0d busy=%0b", level, busy);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=not_finished expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gearbox_sched.md
Name: gearbox_sched

Overview:
Flow-control scheduler that sequences the 16-to-20-bit nibble gearbox. It converts an upstream valid/ready stream and a downstream ready into the gearbox's shift_in/shift_out strobes. It tracks buffer occupancy in nibbles, so the gearbox never overflows or underflows, and it runs a flush sequence that pads with zero words until the buffer drains exactly. It sits between the packet source and the gearbox, and drives the gearbox's data-select mux.

Parameters:
DEPTH, 32, gearbox buffer capacity in nibbles (multiple of 4, max 60)
RD_LAT, 2, cycles from gb_shift_out to valid 20-bit data at gearbox output (1..4)

Ports:
clk  in  1  clock, rising edge
res_n  in  1  asynchronous active-low reset
up_valid  in  1  upstream 16-bit word available
up_ready  out  1  scheduler accepts upstream word this cycle
dn_ready  in  1  downstream can take a 20-bit frame
dn_valid  out  1  20-bit frame valid at gearbox output this cycle
flush  in  1  request drain of all buffered data (single-cycle pulse)
flush_done  out  1  one-cycle pulse: flush complete, buffer empty
gb_shift_in  out  1  write strobe to gearbox (4 nibbles)
gb_shift_out  out  1  read strobe to gearbox (5 nibbles)
gb_pad  out  1  1 = gearbox data_in mux selects 16'h0000 pad word
level  out  6  current occupancy in nibbles, 0..DEPTH
busy  out  1  state != IDLE
frame_cnt  out  16  frames read (see Optional Feature)

Behaviour:
- Reset: state=IDLE, level=0, pad_cnt=0, dn_valid pipe cleared. All outputs are 0, including up_ready. Strobes are forced 0 while res_n=0.
- space_ok = (level <= DEPTH-4). Evaluated on the current level only; a same-cycle read is not credited.
- rd_ok = (level >= 5).
- gb_shift_out (combinational) = dn_ready & rd_ok. This applies in every state except during reset.
- up_ready (combinational) = space_ok & state in {IDLE, RUN}.
- gb_shift_in = (up_valid & up_ready) | (state==FLUSH & pad_cnt!=0 & space_ok).
- gb_pad = 1 only for the FLUSH-state pad write.
- level next = level + 4·gb_shift_in − 5·gb_shift_out. Both strobes in the same cycle give net −1. level must never exceed DEPTH or go negative.
- dn_valid = gb_shift_out delayed by RD_LAT cycles through a shift register. One dn_valid pulse per read, order preserved.
- States:
  - IDLE (level==0): goes to RUN on the first upstream write. On flush, goes to DONE.
  - RUN: normal streaming. On flush, load pad_cnt = level mod 5 (computed on the level value after this cycle's updates). If pad_cnt==0, go to DRAIN; otherwise go to FLUSH.
  - FLUSH: each cycle with space_ok, write one pad word and decrement pad_cnt. When pad_cnt reaches 0, go to DRAIN. Reads continue concurrently.
  - DRAIN: no writes. Reads continue while dn_ready. When level==0, go to DONE.
  - DONE: flush_done=1 for exactly one cycle, then go to IDLE.
- Pad arithmetic: 4·k ≡ −k (mod 5), so k = level mod 5 pad words (0..4) make level a multiple of 5 and the buffer drains to exactly 0.
- flush asserted in FLUSH, DRAIN or DONE is ignored. flush in RUN coincident with an upstream write: the write is accepted and included in the pad count.
- RUN with level reaching 0 and no flush stays in RUN (does not return to IDLE).
- If res_n is asserted mid-flush, everything returns immediately to reset values and no flush_done is emitted.

Optional Feature:
Macro GEARBOX_SCHED_STATS_EN.
- Defined: frame_cnt increments on every gb_shift_out, wraps at 16'hFFFF→0, and resets to 0.
- Undefined: no counter logic is built and frame_cnt is tied to 16'h0000.

Test Plan:
- Reset then hold up_valid=1, dn_ready=0 → 8 writes accepted (level 4,8,..,32), then up_ready=0 with level=32; no gb_shift_out.
- level=32, dn_ready=1, up_valid=0 → reads at 32,27,22,17,12,7; level stops at 2; dn_valid pulses follow each read by RD_LAT=2 cycles.
- Streaming with up_valid=1 and dn_ready=1 on the same cycles → level changes by −1 on cycles with both strobes; no overflow over 200 cycles.
- 3 writes (level=12), then flush with dn_ready=1 → pad_cnt=2, two gb_pad writes, level drains 12→…→0, flush_done pulses once, total 4 frames; busy drops the cycle after DONE.
- flush in IDLE with level=0 → flush_done on the next cycle; no strobes. flush with level=10 → no pads, DRAIN yields 2 frames.
- res_n pulsed low during FLUSH with pad_cnt=1 → all outputs 0 asynchronously, level=0, no flush_done; with the macro defined, frame_cnt=0.
